// File: rtl/addr8s_share_arbiter.sv
// Round-robin front end for one shared 8-bit signed adder: grants a requester, registers its
// operands onto the adder, waits SETTLE cycles, then returns the captured sum with its id.
module addr8s_share_arbiter #(
    parameter int unsigned    NREQ   = 4,
    parameter int unsigned    SETTLE = 1,
    localparam int unsigned   IDW    = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   i_req_valid,
    output logic [NREQ-1:0]   o_req_ready,
    input  logic [NREQ*8-1:0] i_req_a,
    input  logic [NREQ*8-1:0] i_req_b,
    output logic [7:0]        o_add_a,
    output logic [7:0]        o_add_b,
    input  logic [8:0]        i_add_sum,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [8:0]        o_rsp_sum,
    output logic [IDW-1:0]    o_rsp_id
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    localparam logic [2:0] CntLast = 3'(SETTLE - 1);

    state_e         r_state;
    state_e         w_state_nxt;
    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] r_id;
    logic [2:0]     r_cnt;
    logic [7:0]     r_add_a;
    logic [7:0]     r_add_b;
    logic           r_rsp_valid;
    logic [8:0]     r_rsp_sum;
    logic [IDW-1:0] r_rsp_id;

    logic           w_arb_en;
    logic           w_gnt_vld;
    logic [IDW-1:0] w_gnt;
    logic [IDW-1:0] w_scan;
    logic           w_take;
    logic           w_capture;

    // Scan from r_ptr upward, wrapping at NREQ; first valid requester wins.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        w_scan    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_scan = IDW'((32'(r_ptr) + k) % NREQ);
            if (!w_gnt_vld && i_req_valid[w_scan]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = w_scan;
            end
        end
    end

    // Gated by rst so no grant is advertised while reset is held.
    assign w_arb_en  = !rst && ((r_state == StIdle) || ((r_state == StResp) && i_rsp_ready));
    assign w_take    = w_arb_en && w_gnt_vld;
    assign w_capture = (r_state == StExec) && (r_cnt == CntLast);

    always_comb begin
        o_req_ready = '0;
        if (w_take) begin
            o_req_ready[w_gnt] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:  if (w_take) w_state_nxt = StExec;
            StExec:  if (w_capture) w_state_nxt = StResp;
            StResp:  if (i_rsp_ready) w_state_nxt = w_take ? StExec : StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= '0;
            r_id        <= '0;
            r_cnt       <= '0;
            r_add_a     <= '0;
            r_add_b     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_sum   <= '0;
            r_rsp_id    <= '0;
        end else begin
            if (w_take) begin
                r_add_a <= i_req_a[{w_gnt, 3'b000} +: 8];
                r_add_b <= i_req_b[{w_gnt, 3'b000} +: 8];
                r_id    <= w_gnt;
                r_ptr   <= (w_gnt == IDW'(NREQ - 1)) ? '0 : w_gnt + 1'b1;
                r_cnt   <= '0;
            end else if (r_state == StExec) begin
                r_cnt <= r_cnt + 3'd1;
            end
            // add_sum is only looked at here, so X elsewhere never reaches state.
            if (w_capture) begin
                r_rsp_sum   <= i_add_sum;
                r_rsp_id    <= r_id;
                r_rsp_valid <= 1'b1;
            end else if ((r_state == StResp) && i_rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign o_add_a     = r_add_a;
    assign o_add_b     = r_add_b;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_sum   = r_rsp_sum;
    assign o_rsp_id    = r_rsp_id;

endmodule

// File: tb/tb_addr8s_share_arbiter.sv
// Bench for addr8s_share_arbiter: directed checks on a SETTLE=1 instance, then randomized
// traffic on a SETTLE=3 instance against a transaction-level reference model.
module tb_addr8s_share_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // SETTLE=1 instance
    logic [3:0]  v1, rdy1;
    logic [31:0] a1, b1;
    logic [7:0]  adda1, addb1;
    logic [8:0]  sum1, rs1;
    logic        rr1, rv1;
    logic [1:0]  rid1;

    // SETTLE=3 instance
    logic [3:0]  v3, rdy3;
    logic [31:0] a3, b3;
    logic [7:0]  adda3, addb3;
    logic [8:0]  sum3, rs3;
    logic        rr3, rv3;
    logic [1:0]  rid3;

    // External shared adders
    assign sum1 = {adda1[7], adda1} + {addb1[7], addb1};
    assign sum3 = {adda3[7], adda3} + {addb3[7], addb3};

    addr8s_share_arbiter #(.NREQ(4), .SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .i_req_valid(v1), .o_req_ready(rdy1), .i_req_a(a1), .i_req_b(b1),
        .o_add_a(adda1), .o_add_b(addb1), .i_add_sum(sum1), .o_rsp_valid(rv1),
        .i_rsp_ready(rr1), .o_rsp_sum(rs1), .o_rsp_id(rid1)
    );

    addr8s_share_arbiter #(.NREQ(4), .SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .i_req_valid(v3), .o_req_ready(rdy3), .i_req_a(a3), .i_req_b(b3),
        .o_add_a(adda3), .o_add_b(addb3), .i_add_sum(sum3), .o_rsp_valid(rv3),
        .i_rsp_ready(rr3), .o_rsp_sum(rs3), .o_rsp_id(rid3)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] ref_sum(input logic [7:0] a, input logic [7:0] b);
        int s;
        s = int'($signed(a)) + int'($signed(b));
        return s[8:0];
    endfunction

    // One isolated request on dut1, checked through grant, latency, response and release.
    task automatic single_txn(input int id, input logic [7:0] a, input logic [7:0] b,
                              input logic [8:0] exp, input string tag);
        @(negedge clk);
        v1 = 4'(1 << id);
        a1[8*id +: 8] = a;
        b1[8*id +: 8] = b;
        rr1 = 1'b1;
        #1;
        chk({tag, "_gnt"}, rdy1, 32'd1 << id);
        @(negedge clk);
        v1 = 4'd0;
        #1;
        chk({tag, "_rv_early"}, rv1, 0);
        chk({tag, "_add_a"}, adda1, a);
        chk({tag, "_add_b"}, addb1, b);
        @(negedge clk);
        #1;
        chk({tag, "_rv"}, rv1, 1);
        chk({tag, "_sum"}, rs1, exp);
        chk({tag, "_id"}, rid1, id);
        @(negedge clk);
        #1;
        chk({tag, "_rv_drop"}, rv1, 0);
    endtask

    // Reference model state for the randomized run
    bit         pend [4];
    logic [7:0] pa [4];
    logic [7:0] pb [4];
    int         m_ptr, t_g, g, idx, done, cyc;
    bit         have, visible, allowed;
    logic [7:0] m_la, m_lb;
    logic [8:0] m_sum;
    int         m_id;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        v1 = 4'hF; a1 = '0; b1 = '0; rr1 = 1'b0;
        v3 = 4'h0; a3 = '0; b3 = '0; rr3 = 1'b0;

        // Reset state, with every request asserted to confirm no grant leaks out
        @(negedge clk);
        #1;
        chk("rst_ready", rdy1, 0);
        chk("rst_add_a", adda1, 0);
        chk("rst_add_b", addb1, 0);
        chk("rst_rv", rv1, 0);
        chk("rst_sum", rs1, 0);
        chk("rst_id", rid1, 0);
        chk("rst_ready3", rdy3, 0);
        @(negedge clk);
        rst = 1'b0;
        v1 = 4'h0;

        // T1 / T2
        single_txn(0, 8'h7F, 8'h01, 9'h080, "t1");
        single_txn(1, 8'h80, 8'h80, 9'h100, "t2a");
        single_txn(2, 8'hFF, 8'h01, 9'h000, "t2b");
        single_txn(3, 8'h80, 8'h7F, 9'h1FF, "t2c");

        // T3 round robin, pointer is back at 0
        @(negedge clk);
        a1 = 32'h81_7F_F0_12;
        b1 = 32'h80_7F_0F_34;
        v1 = 4'hF;
        rr1 = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            chk("t3_onehot", 32'($countones(rdy1) <= 1), 1);
            if (k % 2 == 0) chk("t3_gnt", rdy1, 32'd1 << ((k / 2) % 4));
            else chk("t3_gnt_exec", rdy1, 0);
            if (k >= 2 && k % 2 == 0) begin
                chk("t3_rv", rv1, 1);
                chk("t3_id", rid1, (k / 2 - 1) % 4);
                chk("t3_sum", rs1, ref_sum(a1[8*((k/2-1)%4) +: 8], b1[8*((k/2-1)%4) +: 8]));
            end
        end
        @(negedge clk);
        v1 = 4'h0;
        @(negedge clk);
        #1;
        chk("t3_last_id", rid1, 1);
        @(negedge clk);
        #1;
        chk("t3_drain", rv1, 0);

        // T4 backpressure, pointer now at 2
        @(negedge clk);
        v1 = 4'b0100;
        rr1 = 1'b0;
        #1;
        chk("t4_gnt2", rdy1, 4'b0100);
        @(negedge clk);
        v1 = 4'b1000;
        #1;
        chk("t4_exec_ready", rdy1, 0);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            #1;
            chk("t4_hold_rv", rv1, 1);
            chk("t4_hold_id", rid1, 2);
            chk("t4_hold_sum", rs1, ref_sum(a1[23:16], b1[23:16]));
            chk("t4_hold_a", adda1, a1[23:16]);
            chk("t4_hold_b", addb1, b1[23:16]);
            chk("t4_hold_ready", rdy1, 0);
        end
        @(negedge clk);
        rr1 = 1'b1;
        #1;
        chk("t4_release_gnt", rdy1, 4'b1000);
        chk("t4_release_rv", rv1, 1);
        @(negedge clk);
        v1 = 4'h0;
        #1;
        chk("t4_gap_rv", rv1, 0);
        chk("t4_next_a", adda1, a1[31:24]);
        @(negedge clk);
        #1;
        chk("t4_next_rv", rv1, 1);
        chk("t4_next_id", rid1, 3);
        chk("t4_next_sum", rs1, ref_sum(a1[31:24], b1[31:24]));
        @(negedge clk);
        #1;
        chk("t4_done", rv1, 0);

        // T5 reset during EXEC
        @(negedge clk);
        v1 = 4'b0100;
        #1;
        chk("t5_gnt", rdy1, 4'b0100);
        @(negedge clk);
        rst = 1'b1;
        v1 = 4'hF;
        #1;
        chk("t5_add_a", adda1, 0);
        chk("t5_add_b", addb1, 0);
        chk("t5_rv", rv1, 0);
        chk("t5_sum", rs1, 0);
        chk("t5_id", rid1, 0);
        chk("t5_ready", rdy1, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t5_no_rsp", rv1, 0);
        chk("t5_restart_gnt", rdy1, 4'b0001);
        @(negedge clk);
        v1 = 4'h0;
        #1;
        chk("t5_no_rsp2", rv1, 0);
        @(negedge clk);
        #1;
        chk("t5_new_rv", rv1, 1);
        chk("t5_new_id", rid1, 0);
        @(negedge clk);

        // T6 randomized traffic on the SETTLE=3 instance
        m_ptr = 0; have = 0; m_la = '0; m_lb = '0; done = 0; cyc = 0; t_g = 0;
        m_sum = '0; m_id = 0;
        for (int i = 0; i < 4; i++) begin
            pend[i] = 0; pa[i] = '0; pb[i] = '0;
        end
        while (done < 10000 && cyc < 60000) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1;
                    pa[i] = 8'($urandom);
                    pb[i] = 8'($urandom);
                end
                v3[i] = pend[i];
                a3[8*i +: 8] = pa[i];
                b3[8*i +: 8] = pb[i];
            end
            rr3 = ($urandom_range(0, 7) != 0);
            #1;
            visible = have && (cyc >= t_g + 4);
            allowed = !have || (visible && rr3);
            g = -1;
            for (int k = 0; k < 4; k++) begin
                idx = (m_ptr + k) % 4;
                if (g < 0 && pend[idx]) g = idx;
            end
            chk("t6_gnt", rdy3, (allowed && g >= 0) ? (32'd1 << g) : 32'd0);
            chk("t6_rv", rv3, 32'(visible));
            if (visible) begin
                chk("t6_sum", rs3, m_sum);
                chk("t6_id", rid3, m_id);
            end
            chk("t6_add_a", adda3, m_la);
            chk("t6_add_b", addb3, m_lb);
            if (visible && rr3) begin
                have = 0;
                done++;
            end
            if (allowed && g >= 0) begin
                have = 1;
                t_g = cyc;
                m_ptr = (g + 1) % 4;
                pend[g] = 0;
                m_la = pa[g];
                m_lb = pb[g];
                m_sum = ref_sum(pa[g], pb[g]);
                m_id = g;
            end
            cyc++;
        end
        if (done < 10000) chk("t6_timeout", done, 10000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
